// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi: N-product vending controller with credit accumulator,
// multi-denomination coin acceptance and greedy coin-by-coin change payout.
//
// Optional feature macro: VEND_TIMEOUT_EN
//   defined   -> inactivity counter refunds credit after TIMEOUT_CYC idle
//                cycles in ACCEPT with non-zero credit
//   undefined -> no counter, credit is held indefinitely
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   coin_valid       coin strobe (one cycle per coin)
//   coin_sel         00=1zl 01=2zl 10=5zl 11=invalid
//   sel_valid        product-select strobe
//   sel_idx          product index
//   cancel           refund request
//   chg_ready        hopper ready for one change coin
//   product_vld      one-hot product release pulse (N_PROD bits)
//   chg_valid        change coin offered
//   chg_coin         change coin denomination (coin_sel encoding)
//   coin_reject      pulse: last coin returned unaccepted
//   sel_err          pulse: out-of-range product index
//   credit           current credit in coin units
//   state_o          0=ACCEPT 1=VEND 2=CHANGE

module vend_ctrl_multi #(
    parameter int                     N_PROD      = 3,
    parameter int                     CW          = 8,
    parameter logic [N_PROD*CW-1:0]   PRICES      = {8'd5, 8'd3, 8'd2},
    parameter int                     MAX_CREDIT  = 20,
    parameter int                     TIMEOUT_CYC = 50_000_000,
    localparam int                    SW          = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              coin_valid,
    input  logic [1:0]        coin_sel,
    input  logic              sel_valid,
    input  logic [SW-1:0]     sel_idx,
    input  logic              cancel,
    input  logic              chg_ready,
    output logic [N_PROD-1:0] product_vld,
    output logic              chg_valid,
    output logic [1:0]        chg_coin,
    output logic              coin_reject,
    output logic              sel_err,
    output logic [CW-1:0]     credit,
    output logic [1:0]        state_o
);

    generate
        if (N_PROD < 1 || N_PROD > 16 || MAX_CREDIT >= (1 << CW)
            || MAX_CREDIT < 1 || TIMEOUT_CYC < 1 || CW < 3) begin : g_bad_cfg
            $error("vend_ctrl_multi: illegal parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_VEND   = 2'd1,
        ST_CHANGE = 2'd2
    } state_t;

    localparam int NTAB = 1 << SW;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   credit_nx;
    logic [SW-1:0]   sel_reg;
    logic [SW-1:0]   sel_reg_nx;
    logic            sel_set;
    logic            sel_set_nx;
    logic            coin_reject_nx;
    logic            sel_err_nx;

    logic [2:0]      coin_val;
    logic [CW:0]     coin_sum;
    logic            coin_ok;
    logic            sel_in_range;
    logic            sel_ok;
    logic            sel_bad;
    logic [CW-1:0]   credit_add;
    logic [CW-1:0]   price;
    logic            vend_go;
    logic            cancel_go;
    logic            tmo;
    logic [1:0]      chg_dec;
    logic [CW-1:0]   chg_amt;

    // Price table padded to a power of two so sel_reg never indexes
    // past the end; padding entries are unreachable.
    logic [CW-1:0]   price_tab [NTAB];

    generate
        for (genvar g = 0; g < NTAB; g++) begin : g_tab
            if (g < N_PROD) begin : g_real
                assign price_tab[g] = PRICES[g*CW +: CW];
            end else begin : g_pad
                assign price_tab[g] = '0;
            end
        end
    endgenerate

    assign price = price_tab[sel_reg];

    always_comb begin
        coin_val = 3'd0;
        unique case (coin_sel)
            2'b00:   coin_val = 3'd1;
            2'b01:   coin_val = 3'd2;
            2'b10:   coin_val = 3'd5;
            default: coin_val = 3'd0;
        endcase
    end

    // One extra bit so the ceiling compare cannot wrap.
    assign coin_sum     = {1'b0, credit} + (CW+1)'(coin_val);
    assign coin_ok      = coin_valid && (coin_sel != 2'b11)
                          && (state == ST_ACCEPT)
                          && (coin_sum <= (CW+1)'(MAX_CREDIT));
    assign sel_in_range = 32'(sel_idx) < N_PROD;
    assign sel_ok       = sel_valid && (state == ST_ACCEPT) && sel_in_range;
    assign sel_bad      = sel_valid && (state == ST_ACCEPT) && !sel_in_range;
    assign credit_add   = coin_ok ? coin_sum[CW-1:0] : credit;
    assign vend_go      = sel_set && (credit >= price);

    // A coin arriving with the cancel is added first, then refunded too.
    assign cancel_go    = (cancel || tmo) && (credit_add != '0);

    // Greedy change denomination, decoded from the registered credit so
    // it stays stable while the hopper stalls.
    always_comb begin
        chg_dec = 2'b00;
        chg_amt = CW'(1);
        if (credit >= CW'(5)) begin
            chg_dec = 2'b10;
            chg_amt = CW'(5);
        end else if (credit >= CW'(2)) begin
            chg_dec = 2'b01;
            chg_amt = CW'(2);
        end
    end

`ifdef VEND_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TW-1:0] tmo_cnt;

    assign tmo = (state == ST_ACCEPT) && (credit != '0)
                 && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state != ST_ACCEPT || credit == '0
                     || coin_ok || sel_ok || tmo) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_nx       = state;
        credit_nx      = credit;
        sel_reg_nx     = sel_reg;
        sel_set_nx     = sel_set;
        coin_reject_nx = coin_valid && !coin_ok;
        sel_err_nx     = sel_bad;
        unique case (state)
            ST_ACCEPT: begin
                credit_nx = credit_add;
                if (cancel_go) begin
                    state_nx   = ST_CHANGE;
                    sel_set_nx = 1'b0;
                end else if (vend_go) begin
                    // Selection is frozen on the vend edge so the product
                    // released is the one whose price was checked.
                    state_nx = ST_VEND;
                end else if (sel_ok) begin
                    sel_reg_nx = sel_idx;
                    sel_set_nx = 1'b1;
                end
            end
            ST_VEND: begin
                credit_nx  = credit - price;
                sel_set_nx = 1'b0;
                state_nx   = (credit != price) ? ST_CHANGE : ST_ACCEPT;
            end
            ST_CHANGE: begin
                if (chg_ready) begin
                    credit_nx = credit - chg_amt;
                    if (credit == chg_amt) begin
                        state_nx = ST_ACCEPT;
                    end
                end
            end
            default: begin
                state_nx = ST_ACCEPT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_ACCEPT;
            credit      <= '0;
            sel_reg     <= '0;
            sel_set     <= 1'b0;
            coin_reject <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            state       <= state_nx;
            credit      <= credit_nx;
            sel_reg     <= sel_reg_nx;
            sel_set     <= sel_set_nx;
            coin_reject <= coin_reject_nx;
            sel_err     <= sel_err_nx;
        end
    end

    always_comb begin
        product_vld = '0;
        if (state == ST_VEND) begin
            for (int i = 0; i < N_PROD; i++) begin
                if (sel_reg == SW'(i)) begin
                    product_vld[i] = 1'b1;
                end
            end
        end
    end

    // CHANGE is only ever entered with credit > 0 and left on the payout
    // that empties it, so the state alone qualifies chg_valid.
    assign chg_valid = (state == ST_CHANGE);
    assign chg_coin  = (state == ST_CHANGE) ? chg_dec : 2'b00;
    assign state_o   = state;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// tb_vend_ctrl_multi: directed self-checking bench for vend_ctrl_multi.
// Uses default prices: product0=2, product1=3, product2=5; MAX_CREDIT=20.

module tb_vend_ctrl_multi;

`ifdef VEND_TIMEOUT_EN
    localparam int TMO = 10;
`else
    localparam int TMO = 50_000_000;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_sel = 2'b00;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_idx = 2'b00;
    logic       cancel = 1'b0;
    logic       chg_ready = 1'b0;
    logic [2:0] product_vld;
    logic       chg_valid;
    logic [1:0] chg_coin;
    logic       coin_reject;
    logic       sel_err;
    logic [7:0] credit;
    logic [1:0] state_o;

    int errors = 0;
    int checks = 0;

    vend_ctrl_multi #(.TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .coin_valid  (coin_valid),
        .coin_sel    (coin_sel),
        .sel_valid   (sel_valid),
        .sel_idx     (sel_idx),
        .cancel      (cancel),
        .chg_ready   (chg_ready),
        .product_vld (product_vld),
        .chg_valid   (chg_valid),
        .chg_coin    (chg_coin),
        .coin_reject (coin_reject),
        .sel_err     (sel_err),
        .credit      (credit),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] c);
        coin_valid = 1'b1;
        coin_sel   = c;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic sel(input logic [1:0] idx);
        sel_valid = 1'b1;
        sel_idx   = idx;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (state_o !== 2'd0) begin
            errors++; $display("FAIL rst_state got=%0d want=0", state_o);
        end
        checks++;
        if (credit !== 8'd0) begin
            errors++; $display("FAIL rst_credit got=%0d want=0", credit);
        end
        checks++;
        if ({product_vld, chg_valid, chg_coin, coin_reject, sel_err} !== 8'h00) begin
            errors++;
            $display("FAIL rst_outs got=%b%b%b%b%b want=0", product_vld,
                     chg_valid, chg_coin, coin_reject, sel_err);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_vend_exact();
        coin(2'b01);
        checks++;
        if (credit !== 8'd2) begin
            errors++; $display("FAIL ex_credit got=%0d want=2", credit);
        end
        sel(2'd0);
        checks++;
        if (state_o !== 2'd0 || product_vld !== 3'b000) begin
            errors++;
            $display("FAIL ex_early st=%0d pv=%b want st=0 pv=000", state_o, product_vld);
        end
        tick();
        checks++;
        if (state_o !== 2'd1 || product_vld !== 3'b001) begin
            errors++;
            $display("FAIL ex_vend st=%0d pv=%b want st=1 pv=001", state_o, product_vld);
        end
        tick();
        checks++;
        if (state_o !== 2'd0 || credit !== 8'd0 || product_vld !== 3'b000
            || chg_valid !== 1'b0) begin
            errors++;
            $display("FAIL ex_done st=%0d cr=%0d pv=%b cv=%b want 0/0/000/0",
                     state_o, credit, product_vld, chg_valid);
        end
    endtask

    task automatic test_vend_change();
        chg_ready = 1'b1;
        coin(2'b10);
        coin(2'b01);
        checks++;
        if (credit !== 8'd7) begin
            errors++; $display("FAIL vc_credit got=%0d want=7", credit);
        end
        sel(2'd1);
        tick();
        checks++;
        if (product_vld !== 3'b010) begin
            errors++; $display("FAIL vc_pv got=%b want=010", product_vld);
        end
        tick();
        checks++;
        if (state_o !== 2'd2 || chg_valid !== 1'b1 || chg_coin !== 2'b01
            || credit !== 8'd4) begin
            errors++;
            $display("FAIL vc_chg1 st=%0d cv=%b cc=%b cr=%0d want 2/1/01/4",
                     state_o, chg_valid, chg_coin, credit);
        end
        tick();
        checks++;
        if (chg_valid !== 1'b1 || chg_coin !== 2'b01 || credit !== 8'd2) begin
            errors++;
            $display("FAIL vc_chg2 cv=%b cc=%b cr=%0d want 1/01/2",
                     chg_valid, chg_coin, credit);
        end
        tick();
        checks++;
        if (state_o !== 2'd0 || chg_valid !== 1'b0 || credit !== 8'd0) begin
            errors++;
            $display("FAIL vc_done st=%0d cv=%b cr=%0d want 0/0/0",
                     state_o, chg_valid, credit);
        end
    endtask

    task automatic test_cancel_stall();
        logic [7:0] exp_cr [3] = '{8'd6, 8'd1, 8'd0};
        logic [1:0] exp_cc [3] = '{2'b10, 2'b00, 2'b00};
        chg_ready = 1'b0;
        coin(2'b10);
        coin(2'b10);
        coin(2'b00);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (chg_valid !== 1'b1 || chg_coin !== 2'b10 || credit !== 8'd11
                || product_vld !== 3'b000) begin
                errors++;
                $display("FAIL cs_stall%0d cv=%b cc=%b cr=%0d pv=%b want 1/10/11/000",
                         i, chg_valid, chg_coin, credit, product_vld);
            end
            if (i == 0) coin_valid = 1'b1;
            tick();
            if (i == 0) begin
                coin_valid = 1'b0;
                checks++;
                if (coin_reject !== 1'b1 || credit !== 8'd11) begin
                    errors++;
                    $display("FAIL cs_coinrej rej=%b cr=%0d want 1/11",
                             coin_reject, credit);
                end
            end
        end
        chg_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (credit !== exp_cr[i] || chg_coin !== exp_cc[i]
                || product_vld !== 3'b000) begin
                errors++;
                $display("FAIL cs_pay%0d cr=%0d cc=%b pv=%b want cr=%0d cc=%b",
                         i, credit, chg_coin, product_vld, exp_cr[i], exp_cc[i]);
            end
        end
        checks++;
        if (state_o !== 2'd0 || chg_valid !== 1'b0) begin
            errors++;
            $display("FAIL cs_done st=%0d cv=%b want 0/0", state_o, chg_valid);
        end
    endtask

    task automatic test_sel_first();
        coin(2'b01);
        coin(2'b00);
        sel(2'd2);
        tick();
        checks++;
        if (state_o !== 2'd0 || product_vld !== 3'b000 || credit !== 8'd3) begin
            errors++;
            $display("FAIL sf_wait st=%0d pv=%b cr=%0d want 0/000/3",
                     state_o, product_vld, credit);
        end
        coin(2'b01);
        checks++;
        if (state_o !== 2'd0 || credit !== 8'd5) begin
            errors++;
            $display("FAIL sf_coin st=%0d cr=%0d want 0/5", state_o, credit);
        end
        tick();
        checks++;
        if (state_o !== 2'd1 || product_vld !== 3'b100) begin
            errors++;
            $display("FAIL sf_vend st=%0d pv=%b want 1/100", state_o, product_vld);
        end
        tick();
        checks++;
        if (state_o !== 2'd0 || credit !== 8'd0) begin
            errors++;
            $display("FAIL sf_done st=%0d cr=%0d want 0/0", state_o, credit);
        end
    endtask

    task automatic test_reject();
        coin(2'b10);
        coin(2'b10);
        coin(2'b10);
        coin(2'b01);
        coin(2'b00);
        checks++;
        if (credit !== 8'd18) begin
            errors++; $display("FAIL rj_credit got=%0d want=18", credit);
        end
        coin(2'b10);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 8'd18) begin
            errors++;
            $display("FAIL rj_over rej=%b cr=%0d want 1/18", coin_reject, credit);
        end
        tick();
        checks++;
        if (coin_reject !== 1'b0) begin
            errors++; $display("FAIL rj_pulse got=%b want=0", coin_reject);
        end
        sel(2'd3);
        checks++;
        if (sel_err !== 1'b1) begin
            errors++; $display("FAIL rj_selerr got=%b want=1", sel_err);
        end
        coin(2'b11);
        checks++;
        if (coin_reject !== 1'b1 || sel_err !== 1'b0 || credit !== 8'd18) begin
            errors++;
            $display("FAIL rj_bad rej=%b serr=%b cr=%0d want 1/0/18",
                     coin_reject, sel_err, credit);
        end
        coin(2'b01);
        checks++;
        if (coin_reject !== 1'b0 || credit !== 8'd20) begin
            errors++;
            $display("FAIL rj_max rej=%b cr=%0d want 0/20", coin_reject, credit);
        end
        chg_ready = 1'b1;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        for (int i = 0; i < 20 && state_o != 2'd0; i++) tick();
        checks++;
        if (state_o !== 2'd0 || credit !== 8'd0) begin
            errors++;
            $display("FAIL rj_drain st=%0d cr=%0d want 0/0", state_o, credit);
        end
    endtask

    task automatic test_coin_cancel();
        chg_ready = 1'b0;
        coin_valid = 1'b1;
        coin_sel = 2'b00;
        cancel = 1'b1;
        tick();
        coin_valid = 1'b0;
        cancel = 1'b0;
        checks++;
        if (state_o !== 2'd2 || credit !== 8'd1 || chg_coin !== 2'b00
            || chg_valid !== 1'b1) begin
            errors++;
            $display("FAIL cc_chg st=%0d cr=%0d cc=%b cv=%b want 2/1/00/1",
                     state_o, credit, chg_coin, chg_valid);
        end
        chg_ready = 1'b1;
        tick();
        checks++;
        if (state_o !== 2'd0 || credit !== 8'd0) begin
            errors++;
            $display("FAIL cc_done st=%0d cr=%0d want 0/0", state_o, credit);
        end
    endtask

    task automatic test_reset_mid();
        chg_ready = 1'b0;
        coin(2'b01);
        coin(2'b01);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checks++;
        if (state_o !== 2'd2 || credit !== 8'd4) begin
            errors++;
            $display("FAIL rm_pre st=%0d cr=%0d want 2/4", state_o, credit);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (state_o !== 2'd0 || credit !== 8'd0 || chg_valid !== 1'b0
            || chg_coin !== 2'b00 || product_vld !== 3'b000) begin
            errors++;
            $display("FAIL rm_async st=%0d cr=%0d cv=%b cc=%b pv=%b want 0",
                     state_o, credit, chg_valid, chg_coin, product_vld);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        chg_ready = 1'b0;
        coin(2'b00);
        for (int i = 0; i < 9; i++) tick();
        checks++;
        if (state_o !== 2'd0 || credit !== 8'd1) begin
            errors++;
            $display("FAIL to_idle st=%0d cr=%0d want 0/1", state_o, credit);
        end
        tick();
`ifdef VEND_TIMEOUT_EN
        checks++;
        if (chg_valid !== 1'b1 || chg_coin !== 2'b00 || credit !== 8'd1) begin
            errors++;
            $display("FAIL to_fire cv=%b cc=%b cr=%0d want 1/00/1",
                     chg_valid, chg_coin, credit);
        end
`else
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (chg_valid !== 1'b0 || state_o !== 2'd0 || credit !== 8'd1) begin
            errors++;
            $display("FAIL to_hold cv=%b st=%0d cr=%0d want 0/0/1",
                     chg_valid, state_o, credit);
        end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
`endif
        chg_ready = 1'b1;
        tick();
        checks++;
        if (state_o !== 2'd0 || credit !== 8'd0) begin
            errors++;
            $display("FAIL to_done st=%0d cr=%0d want 0/0", state_o, credit);
        end
    endtask

    initial begin
        test_reset();
        test_vend_exact();
        test_vend_change();
        test_cancel_stall();
        test_sel_first();
        test_reject();
        test_coin_cancel();
        test_reset_mid();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
